// File: rtl/shift_pkg.sv
// Shared constants and types for the multi-cycle RV32I shift unit.
package shift_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // True for SLL/SRL/SRA and their immediate forms
    function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
        return ((op == OP_IMM) || (op == OP_REG)) && ((f3 == F3_SLL) || (f3 == F3_SR));
    endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift datapath: shifts the accumulator by amt bits.
module shift_step
    import shift_pkg::*;
(
    input  logic [31:0] i_acc,
    input  shift_kind_t i_kind,
    input  logic [4:0]  i_amt,
    output logic [31:0] o_acc
);

    // Select logical-left, logical-right or arithmetic-right shift
    always_comb begin
        o_acc = i_acc;
        case (i_kind)
            SK_SLL:  o_acc = i_acc << i_amt;
            SK_SRL:  o_acc = i_acc >> i_amt;
            SK_SRA:  o_acc = $unsigned($signed(i_acc) >>> i_amt);
            default: o_acc = i_acc;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit and controller for the RV32I execute stage.
// Shifts up to STEP bits per cycle, stalls the pipeline while busy and
// returns the result with a one-cycle done pulse.
// Optional: SHIFT_SEQ_ZERO_FASTPATH_EN sends shamt=0 straight to DONE.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rd2,
    input  logic [31:0] imm,
    output logic [31:0] result,
    output logic        done,
    output logic        stall
);

    if (!((STEP == 1) || (STEP == 2) || (STEP == 4) || (STEP == 8) || (STEP == 16))) begin : g_bad_step
        $error("shift_sequencer: STEP must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    shift_kind_t r_kind;
    logic [31:0] r_result;

    logic        w_accept;
    logic [4:0]  w_shamt;
    shift_kind_t w_kind;
    logic [4:0]  w_amt;
    logic        w_last;
    logic        w_zero_fast;
    logic [31:0] w_step_out;
    logic        w_unused;

    // Only the low five bits of either shamt source are meaningful
    assign w_unused = &{1'b0, rd2[31:5], imm[31:5]};

    assign w_accept = start && is_shift(op, funct3) && (r_state != SHIFT);
    assign w_shamt  = (op == OP_IMM) ? imm[4:0] : rd2[4:0];
    assign w_kind   = (funct3 == F3_SLL) ? SK_SLL : (funct7_5 ? SK_SRA : SK_SRL);
    assign w_amt    = (r_cnt < STEP_AMT) ? r_cnt : STEP_AMT;
    assign w_last   = (r_cnt <= STEP_AMT);

`ifdef SHIFT_SEQ_ZERO_FASTPATH_EN
    assign w_zero_fast = (w_shamt == '0);
`else
    assign w_zero_fast = 1'b0;
`endif

    shift_step u_step (
        .i_acc  (r_acc),
        .i_kind (r_kind),
        .i_amt  (w_amt),
        .o_acc  (w_step_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; flush overrides everything except reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_next = w_zero_fast ? DONE : SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (flush) begin
            w_state_next = IDLE;
        end
    end

    // Done pulse and pipeline stall
    always_comb begin
        done  = (r_state == DONE) && !flush;
        stall = (w_accept || (r_state == SHIFT)) && !flush;
    end

    // Operand capture, iterative shift and result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_kind   <= SK_SLL;
            r_result <= '0;
        end else if (!flush) begin
            if (w_accept) begin
                r_acc  <= rs1_val;
                r_cnt  <= w_shamt;
                r_kind <= w_kind;
                if (w_zero_fast) begin
                    r_result <= rs1_val;
                end
            end else if (r_state == SHIFT) begin
                r_acc <= w_step_out;
                r_cnt <= r_cnt - w_amt;
                if (w_last) begin
                    r_result <= w_step_out;
                end
            end
        end
    end

    assign result = r_result;

endmodule
